// File: rtl/briscv_pkg.sv
// briscv_pkg: shared widths, register index type and writeback source encoding
package briscv_pkg;
  localparam int XLEN = 32;
  localparam int NREG = 32;
  typedef logic [4:0] reg_idx_t;
  typedef enum logic [1:0] {WB_NONE, WB_ALU, WB_LSU} wb_src_e;
endpackage

// File: rtl/wb_scoreboard.sv
// wb_scoreboard: busy bits for registers with an outstanding long-latency result
//   aclk, resetn       clock, synchronous active-low reset
//   set_en, set_rd     mark set_rd busy (index 0 ignored)
//   clr_en, clr_rd     clear clr_rd; a simultaneous set of the same index wins
//   q1_rd/q1_busy, q2_rd/q2_busy  combinational query ports
//   busy               full busy vector, bit 0 always 0
module wb_scoreboard
  import briscv_pkg::*;
#(
  parameter int NREG = briscv_pkg::NREG
) (
  input  logic            aclk,
  input  logic            resetn,
  input  logic            set_en,
  input  reg_idx_t        set_rd,
  input  logic            clr_en,
  input  reg_idx_t        clr_rd,
  input  reg_idx_t        q1_rd,
  input  reg_idx_t        q2_rd,
  output logic            q1_busy,
  output logic            q2_busy,
  output logic [NREG-1:0] busy
);
  logic [NREG-1:0] set_m, clr_m;
  always_comb begin
    set_m = set_en ? NREG'(1) << set_rd : '0;
    clr_m = clr_en ? NREG'(1) << clr_rd : '0;
    q1_busy = busy[q1_rd];
    q2_busy = busy[q2_rd];
  end
  always_ff @(posedge aclk)
    if (!resetn) busy <= '0;
    else busy <= ((busy & ~clr_m) | set_m) & ~NREG'(1);
endmodule

// File: rtl/regfile_writeback.sv
// regfile_writeback: merges ALU and LSU results into the single register-file write port
//   aclk, resetn                    clock, synchronous active-low reset
//   alu_valid/alu_rd/alu_data       single-cycle result, always accepted, highest priority
//   lsu_valid/lsu_ready/lsu_rd/lsu_data  multi-cycle result into a one-entry holding buffer
//   iss_valid/iss_rd                long-latency issue, marks destination busy
//   rs1/rs2, rf_rs1_data/rf_rs2_data decode sources and raw register-file data
//   rs1_data/rs2_data, hazard       corrected operands and decode stall
//   write_en/rd/rd_data             registered register-file write
//   err                             sticky: LSU result for a register that was not busy
//   REGFILE_WB_BYPASS_EN            forward the in-flight write instead of stalling on it
module regfile_writeback
  import briscv_pkg::*;
#(
  parameter int NREG = briscv_pkg::NREG,
  parameter int XLEN = briscv_pkg::XLEN
) (
  input  logic            aclk,
  input  logic            resetn,
  input  logic            alu_valid,
  input  reg_idx_t        alu_rd,
  input  logic [XLEN-1:0] alu_data,
  input  logic            lsu_valid,
  output logic            lsu_ready,
  input  reg_idx_t        lsu_rd,
  input  logic [XLEN-1:0] lsu_data,
  input  logic            iss_valid,
  input  reg_idx_t        iss_rd,
  input  reg_idx_t        rs1,
  input  reg_idx_t        rs2,
  input  logic [XLEN-1:0] rf_rs1_data,
  input  logic [XLEN-1:0] rf_rs2_data,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  output logic            hazard,
  output logic            write_en,
  output reg_idx_t        rd,
  output logic [XLEN-1:0] rd_data,
  output logic            err
);
  logic            hold_v;
  reg_idx_t        hold_rd;
  logic [XLEN-1:0] hold_data;
  wb_src_e         src;
  logic            accept, drain, busy1, busy2, hit1, hit2;
  reg_idx_t        sel_rd;
  logic [XLEN-1:0] sel_data;
  logic [NREG-1:0] busy;
  wb_scoreboard #(.NREG(NREG)) u_sb (
    .aclk(aclk), .resetn(resetn),
    .set_en(iss_valid), .set_rd(iss_rd),
    .clr_en(drain), .clr_rd(hold_rd),
    .q1_rd(rs1), .q2_rd(rs2),
    .q1_busy(busy1), .q2_busy(busy2),
    .busy(busy)
  );
  always_comb begin
    lsu_ready = !hold_v;
    accept = lsu_valid && !hold_v;
    src = alu_valid ? WB_ALU : hold_v ? WB_LSU : WB_NONE;
    drain = src == WB_LSU;
    sel_rd = src == WB_ALU ? alu_rd : hold_rd;
    sel_data = src == WB_ALU ? alu_data : hold_data;
    hit1 = write_en && rd == rs1 && rs1 != '0;
    hit2 = write_en && rd == rs2 && rs2 != '0;
`ifdef REGFILE_WB_BYPASS_EN
    rs1_data = hit1 ? rd_data : rf_rs1_data;
    rs2_data = hit2 ? rd_data : rf_rs2_data;
    hazard = busy1 || busy2;
`else
    rs1_data = rf_rs1_data;
    rs2_data = rf_rs2_data;
    hazard = busy1 || busy2 || hit1 || hit2;
`endif
  end
  always_ff @(posedge aclk)
    if (!resetn) begin
      hold_v <= 1'b0;
      hold_rd <= '0;
      hold_data <= '0;
      write_en <= 1'b0;
      rd <= '0;
      rd_data <= '0;
      err <= 1'b0;
    end else begin
      hold_v <= accept || (hold_v && !drain);
      if (accept) begin
        hold_rd <= lsu_rd;
        hold_data <= lsu_data;
      end
      write_en <= src != WB_NONE && sel_rd != '0;
      if (src != WB_NONE) begin
        rd <= sel_rd;
        rd_data <= sel_data;
      end
      if (accept && lsu_rd != '0 && !busy[lsu_rd]) err <= 1'b1;
    end
endmodule

// File: tb/tb_regfile_writeback.sv
// tb_regfile_writeback: vector, directed and random checks against a spec-level model
module tb_regfile_writeback;
  logic aclk = 0, resetn = 0;
  logic alu_valid = 0, lsu_valid = 0, iss_valid = 0;
  logic [4:0] alu_rd = 0, lsu_rd = 0, iss_rd = 0, rs1 = 0, rs2 = 0;
  logic [31:0] alu_data = 0, lsu_data = 0, rf_rs1_data = 0, rf_rs2_data = 0;
  logic lsu_ready, hazard, write_en, err;
  logic [4:0] rd;
  logic [31:0] rs1_data, rs2_data, rd_data;
  int checks = 0, errors = 0;
  bit m_hold_v, m_err, m_we;
  bit m_busy [32];
  int m_hold_rd, m_rd;
  logic [31:0] m_hold_data, m_data;
  typedef struct {
    logic av;
    logic [4:0] ard;
    logic [31:0] ad;
    logic we;
  } alu_vec_t;
  alu_vec_t vecs [6];
  regfile_writeback dut (
    .aclk(aclk), .resetn(resetn),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
    .iss_valid(iss_valid), .iss_rd(iss_rd),
    .rs1(rs1), .rs2(rs2), .rf_rs1_data(rf_rs1_data), .rf_rs2_data(rf_rs2_data),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .hazard(hazard),
    .write_en(write_en), .rd(rd), .rd_data(rd_data), .err(err)
  );
  always #5 aclk = ~aclk;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", n, a, e, $time);
    end
  endtask
  task automatic idle();
    alu_valid = 0; lsu_valid = 0; iss_valid = 0;
  endtask
  task automatic step();
    bit acc, drained, exp_hz;
    #1;
    exp_hz = m_busy[rs1] || m_busy[rs2];
`ifdef REGFILE_WB_BYPASS_EN
    chk("rs1_data", rs1_data, (m_we && m_rd == rs1 && rs1 != 0) ? m_data : rf_rs1_data);
    chk("rs2_data", rs2_data, (m_we && m_rd == rs2 && rs2 != 0) ? m_data : rf_rs2_data);
`else
    exp_hz = exp_hz || (m_we && m_rd == rs1 && rs1 != 0) || (m_we && m_rd == rs2 && rs2 != 0);
    chk("rs1_data", rs1_data, rf_rs1_data);
    chk("rs2_data", rs2_data, rf_rs2_data);
`endif
    chk("hazard", {31'd0, hazard}, {31'd0, exp_hz});
    chk("lsu_ready", {31'd0, lsu_ready}, {31'd0, !m_hold_v});
    if (!resetn) begin
      m_hold_v = 0; m_err = 0; m_we = 0; m_rd = 0; m_data = 0;
      foreach (m_busy[i]) m_busy[i] = 0;
    end else begin
      acc = lsu_valid && !m_hold_v;
      drained = 0;
      m_we = 0;
      if (alu_valid) begin
        m_we = alu_rd != 0; m_rd = alu_rd; m_data = alu_data;
      end else if (m_hold_v) begin
        m_we = m_hold_rd != 0; m_rd = m_hold_rd; m_data = m_hold_data; drained = 1;
      end
      if (acc && lsu_rd != 0 && !m_busy[lsu_rd]) m_err = 1;
      if (drained) begin
        m_busy[m_hold_rd] = 0; m_hold_v = 0;
      end
      if (iss_valid && iss_rd != 0) m_busy[iss_rd] = 1;
      if (acc) begin
        m_hold_v = 1; m_hold_rd = lsu_rd; m_hold_data = lsu_data;
      end
    end
    @(posedge aclk);
    #1;
    chk("write_en", {31'd0, write_en}, {31'd0, m_we});
    chk("err", {31'd0, err}, {31'd0, m_err});
    if (m_we) begin
      chk("rd", {27'd0, rd}, m_rd);
      chk("rd_data", rd_data, m_data);
    end
  endtask
  task automatic do_reset();
    idle();
    resetn = 0;
    step();
    step();
    chk("rst_rd", {27'd0, rd}, 0);
    chk("rst_rd_data", rd_data, 0);
    resetn = 1;
  endtask
  initial begin
    vecs[0] = '{1, 5'd5, 32'hDEADBEEF, 1};
    vecs[1] = '{1, 5'd0, 32'h11111111, 0};
    vecs[2] = '{0, 5'd6, 32'h22222222, 0};
    vecs[3] = '{1, 5'd31, 32'hFFFFFFFF, 1};
    vecs[4] = '{1, 5'd1, 32'h00000000, 1};
    vecs[5] = '{1, 5'd17, 32'h80000001, 1};
    do_reset();
    chk("rst_write_en", {31'd0, write_en}, 0);
    chk("rst_lsu_ready", {31'd0, lsu_ready}, 1);
    chk("rst_err", {31'd0, err}, 0);
    foreach (vecs[i]) begin
      alu_valid = vecs[i].av; alu_rd = vecs[i].ard; alu_data = vecs[i].ad;
      step();
      chk("vec_we", {31'd0, write_en}, {31'd0, vecs[i].we});
      if (vecs[i].we) begin
        chk("vec_rd", {27'd0, rd}, {27'd0, vecs[i].ard});
        chk("vec_data", rd_data, vecs[i].ad);
      end
    end
    idle(); rs1 = 0; rs2 = 0;
    step();
    iss_valid = 1; iss_rd = 7;
    step();
    idle(); rs1 = 7;
    #1 chk("load_hazard_busy", {31'd0, hazard}, 1);
    lsu_valid = 1; lsu_rd = 7; lsu_data = 32'h1234;
    step();
    chk("load_no_early_write", {31'd0, write_en}, 0);
    idle();
    step();
    chk("load_write_en", {31'd0, write_en}, 1);
    chk("load_rd", {27'd0, rd}, 7);
    chk("load_data", rd_data, 32'h1234);
    #1;
`ifdef REGFILE_WB_BYPASS_EN
    chk("load_hazard_drop", {31'd0, hazard}, 0);
`else
    chk("load_hazard_wb_stall", {31'd0, hazard}, 1);
`endif
    rs1 = 0;
    step();
    iss_valid = 1; iss_rd = 3;
    step();
    idle(); lsu_valid = 1; lsu_rd = 3; lsu_data = 32'h333;
    step();
    lsu_valid = 0;
    for (int k = 0; k < 3; k++) begin
      alu_valid = 1; alu_rd = 5'(20 + k); alu_data = 32'hA00 + k;
      #1 chk("cont_lsu_ready", {31'd0, lsu_ready}, 0);
      step();
      chk("cont_alu_rd", {27'd0, rd}, 20 + k);
    end
    idle();
    step();
    chk("cont_lsu_rd", {27'd0, rd}, 3);
    chk("cont_lsu_data", rd_data, 32'h333);
    iss_valid = 1; iss_rd = 9;
    step();
    idle(); lsu_valid = 1; lsu_rd = 9; lsu_data = 32'h999;
    step();
    idle(); iss_valid = 1; iss_rd = 9;
    step();
    chk("coll_write_rd", {27'd0, rd}, 9);
    idle(); rs1 = 9;
    #1 chk("coll_busy_kept", {31'd0, hazard}, 1);
    step();
    rs1 = 9; rs2 = 9;
    for (int k = 0; k < 6 && m_busy[9]; k++) begin
      lsu_valid = !m_hold_v; lsu_rd = 9; lsu_data = 32'h9999;
      step();
    end
    chk("coll_busy_cleared", {31'd0, m_busy[9]}, 0);
    idle(); rs1 = 0; rs2 = 0;
    step();
    alu_valid = 1; alu_rd = 4; alu_data = 32'hA5;
    step();
    idle(); rs2 = 4; rf_rs2_data = 0;
    #1;
`ifdef REGFILE_WB_BYPASS_EN
    chk("bypass_rs2", rs2_data, 32'hA5);
`else
    chk("nobypass_hazard", {31'd0, hazard}, 1);
`endif
    step();
    rs2 = 0;
    lsu_valid = 1; lsu_rd = 12; lsu_data = 32'hC;
    step();
    idle();
    chk("err_set", {31'd0, err}, 1);
    step(); step();
    chk("err_sticky", {31'd0, err}, 1);
    iss_valid = 1; iss_rd = 5;
    step();
    idle(); lsu_valid = 1; lsu_rd = 5; lsu_data = 32'h55;
    step();
    idle(); rs1 = 5; resetn = 0;
    step();
    chk("rst_mid_no_write", {31'd0, write_en}, 0);
    resetn = 1;
    #1;
    chk("rst_mid_ready", {31'd0, lsu_ready}, 1);
    chk("rst_mid_busy", {31'd0, hazard}, 0);
    chk("rst_mid_err", {31'd0, err}, 0);
    step();
    chk("rst_mid_no_drain", {31'd0, write_en}, 0);
    for (int c = 0; c < 3000; c++) begin
      int nb;
      int cand [$];
      alu_valid = ($urandom_range(0, 9) < 4);
      alu_rd = 5'($urandom); alu_data = $urandom;
      iss_valid = ($urandom_range(0, 9) < 3);
      iss_rd = 5'($urandom);
      rs1 = 5'($urandom); rs2 = ($urandom_range(0, 3) == 0) ? 5'(m_rd) : 5'($urandom);
      rf_rs1_data = $urandom; rf_rs2_data = $urandom;
      if (!lsu_valid) begin
        cand.delete();
        for (int r = 1; r < 32; r++) if (m_busy[r] && !(m_hold_v && m_hold_rd == r)) cand.push_back(r);
        nb = cand.size();
        if (nb > 0 && $urandom_range(0, 1) == 1) begin
          lsu_valid = 1;
          lsu_rd = 5'(cand[$urandom_range(0, nb - 1)]);
          lsu_data = $urandom;
        end
      end
      if (lsu_valid && !m_hold_v) begin
        step();
        lsu_valid = 0;
      end else step();
    end
    idle();
    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
